// File: rtl/mx_pkg.sv
// mx_pkg: shared bf16 / MX constants and the decoder FSM state type.
package mx_pkg;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam int BF16_EXP_BIAS = 127;
  localparam logic [7:0] MX_EXP_NAN = 8'hFF;
  localparam int BF16_SIGN_W = 1;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MANT_W = 7;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/int_to_bf16.sv
// int_to_bf16: converts one signed MX element plus shared exponent to bf16 (RNE, flush/inf clamp).
module int_to_bf16
  import mx_pkg::*;
#(
  parameter int bit_width = 8
) (
  input  logic [bit_width-1:0] x,
  input  logic [7:0]           e,
  output logic [15:0]          y
);
  localparam int WM = bit_width - 1;
  logic                 sgn;
  logic [bit_width-1:0] m;
  logic [WM-1:0]        norm;
  logic [4:0]           p;
  logic [WM+7:0]        ext;
  logic [6:0]           mant;
  logic                 rb, st, up;
  logic [7:0]           sum;
  logic signed [11:0]   ex;
  always_comb begin
    sgn  = x[bit_width-1];
    m    = sgn ? bit_width'(-x) : x;
    p    = '0;
    for (int i = 0; i < bit_width; i++) if (m[i]) p = 5'(i);
    // drop the leading one; the remaining bits line up under the 7-bit mantissa
    norm = WM'(m << (5'(WM) - p));
    ext  = {norm, 8'b0};
    mant = ext[WM+7:WM+1];
    rb   = ext[WM];
    st   = |ext[WM-1:0];
    up   = rb & (st | mant[0]);
    sum  = {1'b0, mant} + 8'(up);
    ex   = 12'({4'b0, e}) - 12'(bit_width - 2) + 12'(p) + 12'(sum[7]);
    y    = (e == MX_EXP_NAN) ? BF16_QNAN :
           (m == '0)         ? 16'h0000 :
           (ex <= 0)         ? {sgn, 15'b0} :
           (ex >= 255)       ? {sgn, 8'hFF, 7'b0} :
                               {sgn, ex[7:0], sum[6:0]};
  end
endmodule

// File: rtl/conv_mxi8tobf16.sv
// conv_mxi8tobf16: MX integer block to bf16 beat streamer; CONV_MXI8TOBF16_OVERLAP_EN enables zero-bubble reload.
module conv_mxi8tobf16
  import mx_pkg::*;
#(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [bit_width*k-1:0] i_mx_vec,
  input  logic [7:0]             i_mx_exp,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [16*lanes-1:0]    o_bf16_vec,
  output logic                   o_valid,
  output logic                   o_last,
  input  logic                   i_ready
);
  localparam int NB = k / lanes;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  state_t                    st;
  logic [BW-1:0]             beat;
  logic [bit_width*k-1:0]    blk;
  logic [7:0]                ex;
  logic                      acc;
  logic [bit_width*lanes-1:0] slice;
  assign o_valid = st == BUSY;
  assign o_last  = o_valid && beat == BW'(NB - 1);
`ifdef CONV_MXI8TOBF16_OVERLAP_EN
  assign o_ready = !i_rst && (st == IDLE || (o_last && i_ready));
`else
  assign o_ready = !i_rst && st == IDLE;
`endif
  assign acc   = i_valid && o_ready;
  assign slice = blk[int'(beat)*lanes*bit_width +: bit_width*lanes];
  for (genvar j = 0; j < lanes; j++) begin : g_lane
    int_to_bf16 #(.bit_width(bit_width)) u_cvt (
      .x(slice[j*bit_width +: bit_width]),
      .e(ex),
      .y(o_bf16_vec[j*16 +: 16])
    );
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st   <= IDLE;
      beat <= '0;
    end else if (acc) begin
      blk  <= i_mx_vec;
      ex   <= i_mx_exp;
      beat <= '0;
      st   <= BUSY;
    end else if (o_valid && i_ready) begin
      beat <= o_last ? '0 : beat + 1'b1;
      st   <= o_last ? IDLE : BUSY;
    end
  end
endmodule

// File: tb/tb_conv_mxi8tobf16.sv
// tb_conv_mxi8tobf16: directed checks of conversion, rounding, clamps, NaN, handshake and reset.
module tb_conv_mxi8tobf16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [255:0] a_vec;
  logic [7:0]   a_exp;
  logic         a_iv, a_ordy, a_ov, a_last, a_ir;
  logic [127:0] a_out;
  logic [95:0]  b_vec;
  logic [7:0]   b_exp;
  logic         b_iv, b_ordy, b_ov, b_last;
  logic [127:0] b_out;
  int n_vec = 0;
  int n_err = 0;
  localparam int T[8] = '{64, -64, 127, 0, -128, 1, 2, -1};
  localparam logic [15:0] X127[8] = '{16'h3F80, 16'hBF80, 16'h3FFE, 16'h0000, 16'hC000, 16'h3C80, 16'h3D00, 16'hBC80};
  localparam logic [15:0] X254[8] = '{16'h7F00, 16'hFF00, 16'h7F7E, 16'h0000, 16'hFF80, 16'h7C00, 16'h7C80, 16'hFC00};
  localparam logic [15:0] X1[8]   = '{16'h0080, 16'h8080, 16'h00FE, 16'h0000, 16'h8100, 16'h0000, 16'h0000, 16'h8000};

  conv_mxi8tobf16 #(.bit_width(8), .k(32), .lanes(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_mx_vec(a_vec), .i_mx_exp(a_exp), .i_valid(a_iv),
    .o_ready(a_ordy), .o_bf16_vec(a_out), .o_valid(a_ov), .o_last(a_last), .i_ready(a_ir)
  );
  conv_mxi8tobf16 #(.bit_width(12), .k(8), .lanes(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_mx_vec(b_vec), .i_mx_exp(b_exp), .i_valid(b_iv),
    .o_ready(b_ordy), .o_bf16_vec(b_out), .o_valid(b_ov), .o_last(b_last), .i_ready(1'b1)
  );

  // lane j of beat b carries T[(j+b)%8], so each beat has distinct contents
  function automatic logic [255:0] mk_blk();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(T[((i % 8) + (i / 8)) % 8]);
    return v;
  endfunction

  function automatic logic [127:0] mk_exp(input int e, input int b);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) begin
      int idx;
      idx = (j + b) % 8;
      r[j*16 +: 16] = e == 127 ? X127[idx] : e == 254 ? X254[idx] : e == 1 ? X1[idx] : 16'h7FC0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; a_vec = '0; a_exp = '0; a_iv = 1'b0; a_ir = 1'b0;
    b_vec = '0; b_exp = '0; b_iv = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(a_ov), 128'(0));
    chk("rst_last", 128'(a_last), 128'(0));
    chk("rst_ready", 128'(a_ordy), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 128'(a_ordy), 128'(1));
    a_vec = mk_blk(); a_exp = 8'd127; a_iv = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      a_iv = 1'b0; a_ir = 1'b0;
      chk($sformatf("e127_beat%0d", b), a_out, mk_exp(127, b));
      chk($sformatf("e127_valid%0d", b), 128'(a_ov), 128'(1));
      chk($sformatf("e127_last%0d", b), 128'(a_last), 128'(b == 3));
      chk($sformatf("busy_ready%0d", b), 128'(a_ordy), 128'(0));
      @(negedge clk);
      chk($sformatf("e127_stall%0d", b), a_out, mk_exp(127, b));
      chk($sformatf("stall_last%0d", b), 128'(a_last), 128'(b == 3));
      a_ir = 1'b1;
      if (b == 3) begin
        a_vec = mk_blk(); a_exp = 8'hFF; a_iv = 1'b1;
      end
    end
    @(negedge clk);
`ifdef CONV_MXI8TOBF16_OVERLAP_EN
    chk("overlap_valid", 128'(a_ov), 128'(1));
`else
    chk("bubble_valid", 128'(a_ov), 128'(0));
    chk("bubble_ready", 128'(a_ordy), 128'(1));
    @(negedge clk);
`endif
    a_iv = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("nan_beat%0d", b), a_out, mk_exp(255, b));
      chk($sformatf("nan_last%0d", b), 128'(a_last), 128'(b == 3));
      @(negedge clk);
    end
    chk("idle_valid", 128'(a_ov), 128'(0));
    chk("idle_ready", 128'(a_ordy), 128'(1));
    a_vec = mk_blk(); a_exp = 8'd254; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    chk("e254_beat0", a_out, mk_exp(254, 0));
    @(negedge clk);
    chk("e254_beat1", a_out, mk_exp(254, 1));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 128'(a_ov), 128'(0));
    chk("midrst_ready", 128'(a_ordy), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", 128'(a_ordy), 128'(1));
    chk("postrst_valid", 128'(a_ov), 128'(0));
    a_vec = mk_blk(); a_exp = 8'd1; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    chk("e1_beat0", a_out, mk_exp(1, 0));
    chk("e1_last0", 128'(a_last), 128'(0));
    @(negedge clk);
    chk("e1_beat1", a_out, mk_exp(1, 1));
    repeat (3) @(negedge clk);
    chk("e1_done", 128'(a_ov), 128'(0));
    b_vec = {12'd0, 12'd0, 12'd1, 12'h800, 12'd0, 12'd1036, 12'd1028, 12'd2047};
    b_exp = 8'd127; b_iv = 1'b1;
    @(negedge clk);
    b_iv = 1'b0;
    chk("w12_valid", 128'(b_ov), 128'(1));
    chk("w12_last", 128'(b_last), 128'(1));
    chk("w12_rne", b_out, {16'h0000, 16'h0000, 16'h3A80, 16'hC000, 16'h0000, 16'h3F82, 16'h3F80, 16'h4000});
    @(negedge clk);
    chk("w12_done", 128'(b_ov), 128'(0));
    chk("w12_ready", 128'(b_ordy), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
